// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer
// Turns the byte stream of an SPI slave into register-bus accesses.
// The first byte after chip select is a command (bit7 read, bit6
// auto-increment, low bits start address). Writes take one data byte per
// access. Reads prefetch one byte ahead: each dummy byte from the master
// triggers the next read.
//
// Ports
//   MClk        : single clock, rising edge
//   USPI_Rst_N  : asynchronous active-low reset
//   Csel_Active : synchronised chip select; low aborts to IDLE
//   Rx_Byte     : received SPI byte, qualified by Rx_Valid (1-cycle pulse)
//   Tx_Byte     : next byte for the MISO shifter, qualified by Tx_Load (pulse)
//   Reg_Addr    : register address
//   Reg_Wdata   : register write data
//   Reg_Wr      : 1-cycle write strobe
//   Reg_Rd      : 1-cycle read strobe
//   Reg_Rdata   : read data, valid with Reg_Ack
//   Reg_Ack     : access complete
//   Err_Count   : saturating count of timeouts and overruns
//   Busy        : not in IDLE
module spi_cmd_sequencer #(
  parameter int ADDR_BITS   = 6,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 MClk,
  input  logic                 USPI_Rst_N,
  input  logic                 Csel_Active,
  input  logic [7:0]           Rx_Byte,
  input  logic                 Rx_Valid,
  output logic [7:0]           Tx_Byte,
  output logic                 Tx_Load,
  output logic [ADDR_BITS-1:0] Reg_Addr,
  output logic [7:0]           Reg_Wdata,
  output logic                 Reg_Wr,
  output logic                 Reg_Rd,
  input  logic [7:0]           Reg_Rdata,
  input  logic                 Reg_Ack,
  output logic [7:0]           Err_Count,
  output logic                 Busy
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WR_DATA, S_WR_WAIT, S_RD_REQ, S_RD_WAIT, S_RD_DATA
  } state_t;

  state_t               state, state_nx;
  logic                 ai, ai_nx;
  logic [TW-1:0]        tmo_cnt, tmo_cnt_nx;
  logic [7:0]           tx_byte_nx;
  logic                 tx_load_nx;
  logic [ADDR_BITS-1:0] addr_nx;
  logic [7:0]           wdata_nx;
  logic                 wr_nx, rd_nx;
  logic                 err_inc;
  logic                 timeout;

  assign Busy    = (state != S_IDLE);
  assign timeout = (tmo_cnt == TMO_LAST) && !Reg_Ack;

  // state register
  always_ff @(posedge MClk or negedge USPI_Rst_N) begin
    if (!USPI_Rst_N) state <= S_IDLE;
    else             state <= state_nx;
  end

  // next-state and next-output logic
  always_comb begin
    state_nx   = state;
    ai_nx      = ai;
    tmo_cnt_nx = '0;
    tx_byte_nx = Tx_Byte;
    tx_load_nx = 1'b0;
    addr_nx    = Reg_Addr;
    wdata_nx   = Reg_Wdata;
    wr_nx      = 1'b0;
    rd_nx      = 1'b0;
    err_inc    = 1'b0;

    if (!Csel_Active) begin
      // Abort wins over everything, including a late ack.
      state_nx   = S_IDLE;
      tx_byte_nx = 8'h00;
    end else begin
      case (state)
        S_IDLE: state_nx = S_CMD;

        S_CMD: if (Rx_Valid) begin
          addr_nx = Rx_Byte[ADDR_BITS-1:0];
          ai_nx   = Rx_Byte[6];
          if (Rx_Byte[7]) begin
            state_nx = S_RD_REQ;
            rd_nx    = 1'b1;
          end else begin
            state_nx = S_WR_DATA;
          end
        end

        S_WR_DATA: if (Rx_Valid) begin
          wdata_nx = Rx_Byte;
          wr_nx    = 1'b1;
          state_nx = S_WR_WAIT;
        end

        S_WR_WAIT: begin
          tmo_cnt_nx = tmo_cnt + 1'b1;
          // Overrun and timeout in one cycle still count as one error.
          err_inc    = Rx_Valid || timeout;
          if (Reg_Ack || timeout) begin
            state_nx = S_WR_DATA;
            if (ai) addr_nx = Reg_Addr + 1'b1;
          end
        end

        S_RD_REQ: begin
          // The strobe was raised on entry; this cycle only drops overruns.
          err_inc  = Rx_Valid;
          state_nx = S_RD_WAIT;
        end

        S_RD_WAIT: begin
          tmo_cnt_nx = tmo_cnt + 1'b1;
          err_inc    = Rx_Valid || timeout;
          if (Reg_Ack || timeout) begin
            tx_byte_nx = Reg_Ack ? Reg_Rdata : 8'hEE;
            tx_load_nx = 1'b1;
            state_nx   = S_RD_DATA;
          end
        end

        S_RD_DATA: if (Rx_Valid) begin
          // Dummy byte from the master: prefetch the next register.
          if (ai) addr_nx = Reg_Addr + 1'b1;
          rd_nx    = 1'b1;
          state_nx = S_RD_REQ;
        end

        default: state_nx = S_IDLE;
      endcase
    end
  end

  // registered outputs and context
  always_ff @(posedge MClk or negedge USPI_Rst_N) begin
    if (!USPI_Rst_N) begin
      ai        <= 1'b0;
      tmo_cnt   <= '0;
      Tx_Byte   <= 8'h00;
      Tx_Load   <= 1'b0;
      Reg_Addr  <= '0;
      Reg_Wdata <= 8'h00;
      Reg_Wr    <= 1'b0;
      Reg_Rd    <= 1'b0;
      Err_Count <= 8'h00;
    end else begin
      ai        <= ai_nx;
      tmo_cnt   <= tmo_cnt_nx;
      Tx_Byte   <= tx_byte_nx;
      Tx_Load   <= tx_load_nx;
      Reg_Addr  <= addr_nx;
      Reg_Wdata <= wdata_nx;
      Reg_Wr    <= wr_nx;
      Reg_Rd    <= rd_nx;
      if (err_inc && (Err_Count != 8'hFF)) Err_Count <= Err_Count + 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
module tb_spi_cmd_sequencer;

  logic       MClk = 1'b0;
  logic       USPI_Rst_N;
  logic       Csel_Active;
  logic [7:0] Rx_Byte;
  logic       Rx_Valid;
  logic [7:0] Tx_Byte;
  logic       Tx_Load;
  logic [5:0] Reg_Addr;
  logic [7:0] Reg_Wdata;
  logic       Reg_Wr, Reg_Rd;
  logic [7:0] Reg_Rdata;
  logic       Reg_Ack;
  logic [7:0] Err_Count;
  logic       Busy;

  int nvec = 0;
  int nmis = 0;

  spi_cmd_sequencer #(.ADDR_BITS(6), .ACK_TIMEOUT(15)) dut (
    .MClk(MClk), .USPI_Rst_N(USPI_Rst_N), .Csel_Active(Csel_Active),
    .Rx_Byte(Rx_Byte), .Rx_Valid(Rx_Valid), .Tx_Byte(Tx_Byte),
    .Tx_Load(Tx_Load), .Reg_Addr(Reg_Addr), .Reg_Wdata(Reg_Wdata),
    .Reg_Wr(Reg_Wr), .Reg_Rd(Reg_Rd), .Reg_Rdata(Reg_Rdata),
    .Reg_Ack(Reg_Ack), .Err_Count(Err_Count), .Busy(Busy)
  );

  always #5 MClk = ~MClk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge MClk);
  endtask

  task automatic rx(input logic [7:0] b);
    Rx_Byte  = b;
    Rx_Valid = 1'b1;
    cyc();
    Rx_Valid = 1'b0;
  endtask

  task automatic ack(input logic [7:0] d);
    Reg_Rdata = d;
    Reg_Ack   = 1'b1;
    cyc();
    Reg_Ack   = 1'b0;
  endtask

  initial begin
    USPI_Rst_N  = 1'b0;
    Csel_Active = 1'b0;
    Rx_Byte     = 8'h00;
    Rx_Valid    = 1'b0;
    Reg_Rdata   = 8'h00;
    Reg_Ack     = 1'b0;
    cyc(); cyc();
    chk("rst_txbyte", Tx_Byte, 8'h00);
    chk("rst_ctl", {Tx_Load, Reg_Wr, Reg_Rd, Busy}, 4'b0000);
    chk("rst_addr", Reg_Addr, 6'd0);
    chk("rst_err", Err_Count, 8'h00);
    USPI_Rst_N = 1'b1;
    cyc();

    // Write with auto-increment
    Csel_Active = 1'b1;
    cyc();
    chk("wr_busy", Busy, 1'b1);
    rx(8'h45);
    chk("wr_cmd_nostrobe", {Reg_Wr, Reg_Rd}, 2'b00);
    rx(8'hA1);
    chk("wr1_strobe", {Reg_Wr, Reg_Rd}, 2'b10);
    chk("wr1_addr", Reg_Addr, 6'd5);
    chk("wr1_data", Reg_Wdata, 8'hA1);
    cyc();
    chk("wr1_pulse", Reg_Wr, 1'b0);
    ack(8'h00);
    rx(8'hB2);
    chk("wr2_strobe", Reg_Wr, 1'b1);
    chk("wr2_addr", Reg_Addr, 6'd6);
    chk("wr2_data", Reg_Wdata, 8'hB2);
    cyc();
    ack(8'h00);
    chk("wr_err", Err_Count, 8'h00);
    Csel_Active = 1'b0;
    cyc();
    chk("wr_idle", Busy, 1'b0);

    // Read with auto-increment across the address wrap
    Csel_Active = 1'b1;
    cyc();
    rx(8'hFF);
    chk("rd1_strobe", {Reg_Wr, Reg_Rd}, 2'b01);
    chk("rd1_addr", Reg_Addr, 6'd63);
    cyc();
    chk("rd1_pulse", Reg_Rd, 1'b0);
    ack(8'h3C);
    chk("rd1_load", Tx_Load, 1'b1);
    chk("rd1_tx", Tx_Byte, 8'h3C);
    cyc();
    chk("rd1_loadpulse", Tx_Load, 1'b0);
    rx(8'h00);
    chk("rd2_strobe", Reg_Rd, 1'b1);
    chk("rd2_wrap_addr", Reg_Addr, 6'd0);
    cyc();
    ack(8'h7D);
    chk("rd2_load", Tx_Load, 1'b1);
    chk("rd2_tx", Tx_Byte, 8'h7D);
    rx(8'h00);
    chk("rd3_addr", Reg_Addr, 6'd1);
    cyc();
    Csel_Active = 1'b0;
    cyc();
    chk("rd_idle_tx", Tx_Byte, 8'h00);
    chk("rd_idle_busy", Busy, 1'b0);

    // Read timeout: Tx_Byte becomes EE 16 cycles after Reg_Rd
    Csel_Active = 1'b1;
    cyc();
    rx(8'h82);
    chk("tmo_strobe", Reg_Rd, 1'b1);
    chk("tmo_addr", Reg_Addr, 6'd2);
    for (int i = 0; i < 15; i++) cyc();
    chk("tmo_early", {Tx_Load, Tx_Byte}, 9'h000);
    cyc();
    chk("tmo_load", Tx_Load, 1'b1);
    chk("tmo_tx", Tx_Byte, 8'hEE);
    chk("tmo_err", Err_Count, 8'd1);
    Csel_Active = 1'b0;
    cyc();

    // Overrun during WR_WAIT, fixed address
    Csel_Active = 1'b1;
    cyc();
    rx(8'h10);
    rx(8'h55);
    chk("ovr_wr", Reg_Wdata, 8'h55);
    rx(8'h66);
    chk("ovr_nostrobe", Reg_Wr, 1'b0);
    chk("ovr_err", Err_Count, 8'd2);
    ack(8'h00);
    chk("ovr_dropped", Reg_Wdata, 8'h55);
    rx(8'h77);
    chk("ovr_next_wr", {Reg_Wr, Reg_Wdata}, 9'h177);
    chk("ai0_addr", Reg_Addr, 6'h10);
    cyc();
    ack(8'h00);
    Csel_Active = 1'b0;
    cyc();

    // Abort in RD_WAIT, then a late ack
    Csel_Active = 1'b1;
    cyc();
    rx(8'h83);
    cyc();
    Csel_Active = 1'b0;
    cyc();
    chk("abort_busy", Busy, 1'b0);
    ack(8'h99);
    chk("abort_noload", {Tx_Load, Tx_Byte}, 9'h000);
    chk("abort_nostrobe", {Reg_Wr, Reg_Rd, Busy}, 3'b000);

    // Asynchronous reset while in WR_WAIT
    Csel_Active = 1'b1;
    cyc();
    rx(8'h41);
    rx(8'hAA);
    chk("arst_pre_wr", Reg_Wr, 1'b1);
    #2;
    USPI_Rst_N = 1'b0;
    #1;
    chk("arst_ctl", {Tx_Load, Reg_Wr, Reg_Rd, Busy}, 4'b0000);
    chk("arst_addr", Reg_Addr, 6'd0);
    chk("arst_data", {Reg_Wdata, Tx_Byte}, 16'h0000);
    chk("arst_err", Err_Count, 8'h00);
    cyc();
    USPI_Rst_N = 1'b1;
    cyc();
    chk("arst_release", Busy, 1'b1);
    Csel_Active = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 6: register address width.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 15: maximum number of MClk cycles to wait for Reg_Ack.
REQ-003 SHALL have port MClk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port USPI_Rst_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port Csel_Active, input, 1 bit: SPI chip select is asserted, already synchronised.
REQ-006 SHALL have port Rx_Byte, input, 8 bits: the received SPI byte.
REQ-007 SHALL have port Rx_Valid, input, 1 bit: one-cycle pulse; Rx_Byte is valid.
REQ-008 SHALL have port Tx_Byte, output, 8 bits: the next byte for the MISO shifter.
REQ-009 SHALL have port Tx_Load, output, 1 bit: one-cycle pulse; Tx_Byte is updated.
REQ-010 SHALL have port Reg_Addr, output, ADDR_BITS: register address.
REQ-011 SHALL have port Reg_Wdata, output, 8 bits: register write data.
REQ-012 SHALL have ports Reg_Wr and Reg_Rd, outputs, 1 bit each: one-cycle request strobes.
REQ-013 SHALL have port Reg_Rdata, input, 8 bits: read data, valid when Reg_Ack is high.
REQ-014 SHALL have port Reg_Ack, input, 1 bit: register access is complete.
REQ-015 SHALL have port Err_Count, output, 8 bits: saturating error counter.
REQ-016 SHALL have port Busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-017 SHALL decode the first byte after Csel_Active rises as the command byte: bit7 RW (1 = read), bit6 AI (auto-increment), bits[ADDR_BITS-1:0] start address.
REQ-018 SHALL implement the states IDLE, CMD, WR_DATA, WR_WAIT, RD_REQ, RD_WAIT, RD_DATA.
REQ-019 SHALL move IDLE->CMD when Csel_Active is 1.
REQ-020 In CMD, on Rx_Valid, SHALL latch the address and then go to RD_REQ if RW=1, otherwise to WR_DATA.
REQ-021 In WR_DATA, on Rx_Valid, SHALL drive Reg_Wdata=Rx_Byte and pulse Reg_Wr for 1 cycle on the next edge, then go to WR_WAIT.
REQ-022 In WR_WAIT, on Reg_Ack, SHALL return to WR_DATA, incrementing Reg_Addr if AI=1.
REQ-023 RD_REQ SHALL pulse Reg_Rd for 1 cycle, then go to RD_WAIT.
REQ-024 In RD_WAIT, on Reg_Ack, SHALL register Tx_Byte=Reg_Rdata, pulse Tx_Load on the following cycle, and go to RD_DATA.
REQ-025 In RD_DATA, each Rx_Valid (a dummy byte) SHALL advance Reg_Addr if AI=1 and go to RD_REQ, so the next read is prefetched.
REQ-026 Latency from Rx_Valid to the Reg_Wr or Reg_Rd strobe SHALL be exactly 1 MClk cycle.
REQ-027 Latency from Reg_Ack to Tx_Load SHALL be exactly 1 MClk cycle.
REQ-028 Address increment SHALL wrap modulo 2^ADDR_BITS, e.g. 63->0 at the default width.
REQ-029 When AI=0, the address SHALL stay fixed for the whole transaction.
REQ-030 Timeout: if Reg_Ack is absent for ACK_TIMEOUT cycles in WR_WAIT or RD_WAIT, the block SHALL increment Err_Count and continue as if acked.
REQ-031 On a read timeout, the byte loaded to Tx_Byte SHALL be 8'hEE.
REQ-032 Overrun: an Rx_Valid arriving in WR_WAIT, RD_REQ or RD_WAIT SHALL be dropped, and Err_Count SHALL increment.
REQ-033 The current access SHALL complete normally after an overrun.
REQ-034 Err_Count SHALL saturate at 8'hFF.
REQ-035 If an overrun and a timeout occur in the same cycle, Err_Count SHALL increment by 1 only.
REQ-036 Csel_Active=0 in any state SHALL force IDLE on the next edge, with no new strobes issued.
REQ-037 An ack arriving after a Csel_Active=0 abort SHALL be ignored.
REQ-038 Tx_Byte SHALL be cleared to 0 when the block enters IDLE.
REQ-039 Reg_Ack seen outside WR_WAIT and RD_WAIT SHALL be ignored.
REQ-040 Reg_Wr and Reg_Rd SHALL never be high in the same cycle.

Reset
REQ-041 USPI_Rst_N=0 SHALL asynchronously force state IDLE.
REQ-042 During reset SHALL hold Tx_Byte=0, Tx_Load=0, Reg_Addr=0, Reg_Wdata=0, Reg_Wr=0, Reg_Rd=0, Err_Count=0 and Busy=0.
REQ-043 Reset asserted mid-transaction SHALL abort it with no further strobes issued.
REQ-044 Reset release SHALL take effect on the first MClk edge after USPI_Rst_N rises.

Verification
REQ-045 Write, AI=1: command 8'h45, data 8'hA1 then 8'hB2, ack after 2 cycles -> Reg_Wr at address 5 with data A1, then at address 6 with data B2; Err_Count=0.
REQ-046 Read, AI=1 at the wrap boundary: command 8'hFF (address 63), Rdata 8'h3C then 8'h7D, followed by 2 dummy bytes -> Tx_Load with 3C, then the next read is at address 0 and Tx_Load carries 7D.
REQ-047 Read timeout: command 8'h82 with Reg_Ack never asserted -> Tx_Byte=8'hEE exactly 16 cycles after Reg_Rd; Err_Count=1.
REQ-048 Overrun: a second Rx_Valid during WR_WAIT -> that byte is not written and Err_Count increments by 1.
REQ-049 Csel_Active dropped while in RD_WAIT, then a late Reg_Ack -> IDLE on the next edge, no Tx_Load, Busy=0.
REQ-050 Asynchronous reset pulse while in WR_WAIT -> all outputs reach their reset values without waiting for an MClk edge.
